// File: rtl/cpu_core_p.sv
// cpu_core_p: parametrised multi-cycle 16-bit-instruction CPU core.
// Handshaked instruction fetch, bounded data-memory wait, sticky halt/error.
module cpu_core_p #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        flags,
    output logic              done,
    output logic              err
);
    localparam int MSB = DATA_W - 1;
    localparam int CW  = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_WB, S_MEM, S_HALT
    } state_t;

    state_t state, state_n;

    logic [15:0]       ir;
    logic [DATA_W-1:0] rf [8];
    logic [CW-1:0]     cnt;

    logic [3:0]        op;
    logic [3:0]        imm;
    logic [DATA_W-1:0] ra, rb, immd, opb, res;
    logic [ADDR_W-1:0] imma, ea, pc_inc;
    logic [DATA_W:0]   sum, dif;
    logic              cf, vf, cin;
    logic              is_alu, is_mem, is_halt;
    logic              accept, last;

    assign op     = ir[15:12];
    assign imm    = ir[3:0];
    assign ra     = rf[ir[11:9]];
    assign rb     = rf[ir[7:5]];
    assign immd   = DATA_W'(imm);
    assign imma   = ADDR_W'(imm);
    assign ea     = ADDR_W'(rb) + imma;
    assign pc_inc = pc + ADDR_W'(1);
    assign accept = instr_valid && instr_ready && (state == S_IDLE);
    assign last   = (cnt == CW'(MEM_TIMEOUT - 1));

    assign is_halt = (op == 4'hF);
    assign is_mem  = (op == 4'h9) || (op == 4'hA);
    assign is_alu  = (op != 4'h0) && (op != 4'hB) && (op != 4'hC)
                  && !is_mem && !is_halt;

    always_comb begin
        res = '0;
        cf  = 1'b0;
        vf  = 1'b0;
        opb = (op == 4'h6) ? immd : rb;
        cin = (op == 4'hE) && flags[1];
        sum = {1'b0, ra} + {1'b0, opb} + {{DATA_W{1'b0}}, cin};
        dif = {1'b0, ra} - {1'b0, rb};
        unique case (op)
            4'h1, 4'h6, 4'hE: begin
                res = sum[MSB:0];
                cf  = sum[DATA_W];
                vf  = (ra[MSB] == opb[MSB]) && (res[MSB] != ra[MSB]);
            end
            4'h2, 4'hD: begin
                res = dif[MSB:0];
                cf  = dif[DATA_W];
                vf  = (ra[MSB] != rb[MSB]) && (res[MSB] != ra[MSB]);
            end
            4'h3: res = ra & rb;
            4'h4: res = ra | rb;
            4'h5: res = ra ^ rb;
            4'h7: res = ra << imm;
            4'h8: res = ra >> imm;
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (accept) state_n = S_EXEC;
            S_EXEC: begin
                unique case (1'b1)
                    is_alu:  state_n = S_WB;
                    is_mem:  state_n = S_MEM;
                    is_halt: state_n = S_HALT;
                    default: state_n = S_IDLE;
                endcase
            end
            S_WB:   state_n = S_IDLE;
            S_MEM:  if (mem_ready || last) state_n = S_IDLE;
            S_HALT: state_n = S_HALT;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ir          <= '0;
            cnt         <= '0;
            instr_ready <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            pc          <= '0;
            flags       <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            state       <= state_n;
            instr_ready <= (state_n == S_IDLE);
            unique case (state)
                S_IDLE: if (accept) ir <= instr;
                S_EXEC: begin
                    unique case (1'b1)
                        is_alu: ;
                        is_mem: begin
                            mem_req   <= 1'b1;
                            mem_we    <= (op == 4'hA);
                            mem_addr  <= ea;
                            mem_wdata <= ra;
                            cnt       <= '0;
                        end
                        is_halt: done <= 1'b1;
                        default: begin
                            if (op == 4'hC)
                                pc <= pc + imma;
                            else if (op == 4'hB && rb == '0)
                                pc <= pc + imma;
                            else
                                pc <= pc_inc;
                        end
                    endcase
                end
                S_WB: begin
                    if (op != 4'hD) rf[ir[11:9]] <= res;
                    flags <= {res == '0, res[MSB], cf, vf};
                    pc    <= pc_inc;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (!mem_we) rf[ir[11:9]] <= mem_rdata;
                        mem_req <= 1'b0;
                        pc      <= pc_inc;
                    end else if (last) begin
                        err     <= 1'b1;
                        mem_req <= 1'b0;
                        pc      <= pc_inc;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_core_p.sv
// tb_cpu_core_p: random and directed checks of cpu_core_p against
// an arithmetic reference model of the instruction set.
module tb_cpu_core_p;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int TO = 4;
    localparam int DM = 1 << DW;
    localparam int AM = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          instr_valid = 1'b0;
    logic [15:0]   instr = '0;
    logic          instr_ready;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr, pc;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    flags;
    logic          done, err;

    cpu_core_p #(.DATA_W(DW), .ADDR_W(AW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .pc(pc), .flags(flags), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    int       mr [8];
    int       mpc;
    bit [3:0] mfl;
    bit       mdone, merr;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sx(input int x);
        return (x >= DM / 2) ? x - DM : x;
    endfunction

    function automatic logic [15:0] mk(input int op, input int rd,
                                       input int rs, input int im);
        logic [15:0] w;
        w = {op[3:0], rd[2:0], 1'b0, rs[2:0], 1'b0, im[3:0]};
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mr[i] = 0;
        mpc = 0; mfl = '0; mdone = 0; merr = 0;
    endtask

    task automatic chk_reset_outs();
        chk("rst_ready", instr_ready, 0);
        chk("rst_outs", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
        chk("rst_state", {pc, flags, done, err}, 0);
    endtask

    // Issue one instruction; dly = MEM cycle in which mem_ready rises
    // (values beyond the timeout, or <= 0, never raise it).
    task automatic run(input logic [15:0] ins, input int dly,
                       input int rdata);
        int op, rd, rs, im, a, b, ea, cyc, m, n;
        int exp_lat, exp_m, res, s, sv, bb, cin, c, v;
        bit ok;
        op = int'(ins[15:12]); rd = int'(ins[11:9]);
        rs = int'(ins[7:5]);   im = int'(ins[3:0]);
        a = mr[rd]; b = mr[rs];
        ea = (b + im) % AM;
        instr_valid = 1'b1;
        instr = ins;
        n = 0;
        while (!instr_ready && n < 50) begin tick(); n++; end
        chk("accept", instr_ready, 1);
        tick();
        instr_valid = 1'b0;
        instr = 16'($urandom);
        cyc = 1; m = 0;
        while (!instr_ready && !done && cyc < 40) begin
            if (mem_req) begin
                m++;
                chk("mem_addr", mem_addr, ea);
                chk("mem_we", mem_we, op == 10);
                chk("mem_wdata", mem_wdata, a);
                mem_ready = (m == dly);
                mem_rdata = DW'(rdata);
            end else begin
                mem_ready = 1'($urandom);
                mem_rdata = DW'($urandom);
            end
            tick();
            cyc++;
        end
        mem_ready = 1'b0;

        ok = (dly >= 1 && dly <= TO);
        exp_m = ok ? dly : TO;
        exp_lat = 3;
        res = 0; c = 0; v = 0;
        case (op)
            0:  begin mpc += 1; exp_lat = 2; end
            1, 6, 14: begin
                bb  = (op == 6) ? im : b;
                cin = (op == 14) ? int'(mfl[1]) : 0;
                s   = a + bb + cin;
                sv  = sx(a) + sx(bb) + cin;
                res = s % DM;
                c   = s >= DM;
                v   = sv < -DM / 2 || sv >= DM / 2;
            end
            2, 13: begin
                res = (a - b + DM) % DM;
                c   = a < b;
                sv  = sx(a) - sx(b);
                v   = sv < -DM / 2 || sv >= DM / 2;
            end
            3:  res = a & b;
            4:  res = a | b;
            5:  res = a ^ b;
            7:  res = (im >= DW) ? 0 : (a << im) % DM;
            8:  res = (im >= DW) ? 0 : a >> im;
            9, 10: begin
                if (ok && op == 9) mr[rd] = rdata;
                if (!ok) merr = 1;
                mpc += 1;
                exp_lat = 2 + exp_m;
                chk("mem_cycles", m, exp_m);
            end
            11: begin mpc += (b == 0) ? im : 1; exp_lat = 2; end
            12: begin mpc += im; exp_lat = 2; end
            default: begin mdone = 1; exp_lat = 2; end
        endcase
        if (op >= 1 && op <= 8 || op == 13 || op == 14) begin
            if (op != 13) mr[rd] = res;
            mfl = {res == 0, res >= DM / 2, c[0], v[0]};
            mpc += 1;
        end
        mpc %= AM;
        chk("latency", cyc, exp_lat);
        chk("pc", pc, mpc);
        chk("flags", flags, mfl);
        chk("done_err", {done, err}, {mdone, merr});
        chk("req_idle", mem_req, 0);
    endtask

    initial begin
        model_reset();
        tick(); tick();
        chk_reset_outs();
        rst = 1'b0;
        tick();
        chk("ready_after_rst", instr_ready, 1);

        run(mk(9, 1, 0, 0), 1, 8'hF5);
        run(mk(6, 1, 0, 15), 0, 0);
        chk("addi_flags", flags, 4'b0010);

        run(mk(9, 2, 0, 0), 2, 8'h7F);
        run(mk(9, 3, 0, 0), 1, 8'h01);
        run(mk(1, 2, 3, 0), 0, 0);
        chk("add_flags", flags, 4'b0101);
        run(mk(14, 2, 3, 0), 0, 0);
        chk("adc_c", flags[1], 0);
        run(mk(13, 3, 2, 0), 0, 0);
        chk("cmp_c", flags[1], 1);
        run(mk(10, 3, 0, 0), 1, 0);

        run(mk(9, 5, 0, 0), 1, 8'hFF);
        run(mk(9, 4, 0, 0), 3, 8'h5A);
        run(mk(10, 4, 5, 2), 4, 0);

        run(mk(9, 6, 0, 0), 0, 8'h33);
        chk("timeout_err", err, 1);
        run(mk(0, 0, 0, 0), 0, 0);
        run(mk(10, 6, 0, 0), 1, 0);

        for (int k = 0; k < 40 && (mpc < 'hEF || mpc > 'hFD); k++)
            run(mk(12, 0, 0, 15), 0, 0);
        run(mk(12, 0, 0, 'hFE - mpc), 0, 0);
        chk("pc_fe", pc, 8'hFE);
        run(mk(12, 0, 0, 3), 0, 0);
        chk("jmp_wrap", pc, 8'h01);
        run(mk(9, 7, 0, 0), 1, 0);
        run(mk(11, 0, 7, 0), 0, 0);
        chk("brz_zero", pc, 8'h02);

        instr_valid = 1'b1;
        instr = mk(9, 3, 0, 1);
        while (!instr_ready) tick();
        tick();
        instr_valid = 1'b0;
        tick();
        chk("midmem_req", mem_req, 1);
        mem_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("midmem_drop", mem_req, 0);
        chk_reset_outs();
        rst = 1'b0;
        model_reset();
        tick();
        run(mk(10, 3, 0, 0), 1, 0);

        for (int k = 0; k < 250; k++) begin
            logic [15:0] w;
            w = 16'($urandom);
            w[15:12] = 4'($urandom_range(0, 14));
            run(w, $urandom_range(1, TO + 2), $urandom_range(0, DM - 1));
        end
        for (int r = 0; r < 8; r++) run(mk(10, r, 0, r), 1, 0);

        run(mk(15, 0, 0, 0), 0, 0);
        instr_valid = 1'b1;
        instr = mk(0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("halt_hold", {instr_ready, done}, 2'b01);
        end
        instr_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk_reset_outs();
        rst = 1'b0;
        model_reset();
        tick();
        run(mk(6, 1, 0, 5), 0, 0);
        run(mk(10, 1, 0, 0), 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
